// File: rtl/bus_decoder.sv
// Address decoder and response router between the picorv32 native memory port and its slaves.
// One transaction at a time; unmapped accesses and overlong slave accesses are completed locally.
module bus_decoder #(
  parameter logic [31:0] MEM_SIZE = 32'h0001_0000,
  parameter logic [31:0] PER_BASE = 32'hFFFF_0000,
  parameter logic [31:0] PER_SIZE = 32'h0000_0100,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        per_valid,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic        per_ready,
  input  logic [31:0] per_rdata,

  input  logic        err_clr,
  output logic        err_unmapped,
  output logic        err_timeout,
  output logic [31:0] err_addr
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  // 33-bit end address so the upper bound never wraps in the compare
  localparam logic [32:0]    PerEnd = {1'b0, PER_BASE} + {1'b0, PER_SIZE};

  typedef enum logic [1:0] {StIdle, StMem, StPer, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_unmapped_q, err_timeout_q;
  logic [31:0]     err_addr_q;

  logic            in_mem, in_per;
  logic            slave_ready;
  logic [31:0]     slave_rdata;
  logic            expired;
  logic            set_unmapped, set_timeout;

  assign in_mem = cpu_addr < MEM_SIZE;
  assign in_per = ({1'b0, cpu_addr} >= {1'b0, PER_BASE}) && ({1'b0, cpu_addr} < PerEnd);

  assign slave_ready = (state_q == StPer) ? per_ready : mem_ready;
  assign slave_rdata = (state_q == StPer) ? per_rdata : mem_rdata;
  assign expired     = (cnt_q == CntMax);

  assign mem_instr = cpu_instr;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_wstrb = cpu_wstrb;
  assign per_addr  = cpu_addr;
  assign per_wdata = cpu_wdata;
  assign per_wstrb = cpu_wstrb;

  assign err_unmapped = err_unmapped_q;
  assign err_timeout  = err_timeout_q;
  assign err_addr     = err_addr_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    mem_valid    = 1'b0;
    per_valid    = 1'b0;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    set_unmapped = 1'b0;
    set_timeout  = 1'b0;

    // A transaction caught by reset is abandoned without a response.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (cpu_valid) begin
            if (in_mem) begin
              state_d = StMem;
            end else if (in_per) begin
              state_d = StPer;
            end else begin
              state_d = StErr;
            end
          end
        end

        StMem, StPer: begin
          mem_valid = (state_q == StMem) && cpu_valid;
          per_valid = (state_q == StPer) && cpu_valid;
          if (!cpu_valid) begin
            state_d = StIdle;
          end else if (slave_ready) begin
            // Slave completion wins over an expiry in the same cycle.
            cpu_ready = 1'b1;
            cpu_rdata = slave_rdata;
            state_d   = StIdle;
          end else if (expired) begin
            cpu_ready   = 1'b1;
            set_timeout = 1'b1;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        StErr: begin
          state_d = StIdle;
          if (cpu_valid) begin
            cpu_ready    = 1'b1;
            set_unmapped = 1'b1;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      err_unmapped_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_unmapped_q <= set_unmapped | (err_unmapped_q & ~err_clr);
      err_timeout_q  <= set_timeout | (err_timeout_q & ~err_clr);
      if (set_unmapped || set_timeout) begin
        err_addr_q <= cpu_addr;
      end
    end
  end

  a_one_slave : assert property (@(posedge clk) disable iff (rst) !(mem_valid && per_valid));
  a_ready_req : assert property (@(posedge clk) disable iff (rst) cpu_ready |-> cpu_valid);

endmodule

// File: doc/bus_decoder.md
Name: bus_decoder

Overview:
Address decoder and response router between the picorv32 native memory port and its slaves.
- Takes one CPU-side transaction at a time and steers it to the main memory port or the peripheral port, by address.
- Completes unmapped accesses itself, and aborts slave accesses that exceed a cycle budget.
- Sits directly upstream of the memory block, in the CPU-to-memory path.

Parameters:
MEM_SIZE, 32'h00010000, bytes of memory region starting at 0x00000000 (power of two)
PER_BASE, 32'hFFFF0000, peripheral region base (aligned to PER_SIZE)
PER_SIZE, 32'h00000100, bytes of peripheral region (power of two)
TIMEOUT, 16, max cycles a slave may take before forced completion (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active high
cpu_valid  in  1  CPU request valid
cpu_instr  in  1  instruction fetch flag
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_wstrb  in  4  byte write strobes, 0 = read
cpu_ready  out  1  transaction complete
cpu_rdata  out  32  read data, valid when cpu_ready
mem_valid, mem_instr  out  1 each  memory request
mem_addr, mem_wdata  out  32 each  passthrough of cpu_addr/cpu_wdata
mem_wstrb  out  4  passthrough of cpu_wstrb
mem_ready  in  1  memory complete
mem_rdata  in  32  memory read data
per_valid  out  1  peripheral request
per_addr, per_wdata  out  32 each  passthrough
per_wstrb  out  4  passthrough
per_ready  in  1  peripheral complete
per_rdata  in  32  peripheral read data
err_clr  in  1  clears sticky error flags
err_unmapped  out  1  sticky: unmapped access occurred
err_timeout  out  1  sticky: slave timeout occurred
err_addr  out  32  address of most recent error

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, timeout counter=0.
  - err_unmapped=0, err_timeout=0, err_addr=0.
  - With state IDLE: cpu_ready=0, cpu_rdata=0, mem_valid=0, per_valid=0.
  - Reset mid-transaction abandons it; no ready is issued.
- FSM states: IDLE, MEM, PER, ERR.
- IDLE: when cpu_valid=1, decode registered cpu_addr:
  - addr < MEM_SIZE -> MEM.
  - PER_BASE <= addr < PER_BASE+PER_SIZE -> PER.
  - Otherwise -> ERR.
  - No outputs asserted in IDLE. Decode costs exactly 1 cycle.
- MEM: mem_valid = cpu_valid (combinational).
  - cpu_ready = mem_ready and cpu_rdata = mem_rdata, combinational and gated by state.
  - On mem_ready -> IDLE, so mem_valid drops the next cycle.
  - Total latency = memory latency + 1.
- PER: same as MEM using the per_* signals. mem_valid=0.
- ERR: for one cycle cpu_ready=1 and cpu_rdata=32'h00000000, then -> IDLE.
  - Writes are dropped.
  - Set err_unmapped=1; err_addr=cpu_addr.
- Timeout:
  - Counter clears on entry to MEM/PER and increments each cycle in MEM/PER.
  - If the count reaches TIMEOUT-1 with no slave ready: cpu_ready=1, cpu_rdata=0, slave valid deasserted next cycle, -> IDLE.
  - Set err_timeout=1; err_addr=cpu_addr.
  - Slave ready in the same cycle as expiry: normal completion, no error.
- cpu_valid drops while in MEM/PER/ERR: -> IDLE, no ready, no error (protocol violation, tolerated).
- Passthrough: mem_addr, mem_wdata, mem_wstrb, mem_instr, per_addr, per_wdata, per_wstrb = cpu_* at all times; only the valids are gated.
- Sticky flags:
  - Set-on-error has priority over err_clr in the same cycle.
  - err_clr alone clears both flags; err_addr holds its value.
- Back-to-back transactions: a new cpu_valid on the cycle after cpu_ready is decoded normally. There is at least one IDLE cycle per transaction.
- Address boundaries use full 32-bit compares with no wrap; PER_BASE+PER_SIZE must not overflow.

Test Plan:
- Write 0x12345678 to 0x00000100, wstrb=1111, then read back (memory, 1-cycle ready) -> mem_valid one cycle after cpu_valid, cpu_rdata=0x12345678, per_valid never high.
- Read 0xFFFF0004 with per_rdata=0xCAFEBABE and per_ready after 3 cycles -> cpu_ready 4 cycles after cpu_valid, rdata=0xCAFEBABE, mem_valid stays 0.
- Read 0x80000000 -> cpu_ready on cycle 2, rdata=0, err_unmapped=1, err_addr=0x80000000; then pulse err_clr -> flag 0, err_addr held.
- Peripheral access to 0xFFFF0010 with per_ready held low, TIMEOUT=16 -> cpu_ready once at count 15, rdata=0, err_timeout=1; per_ready asserted exactly at count 15 instead -> no error, per_rdata returned.
- Assert rst while in MEM awaiting mem_ready -> next cycle mem_valid=0, cpu_ready=0, all flags 0; a subsequent fetch from 0x00000000 completes normally.
- err_clr asserted in the same cycle as a new unmapped access -> err_unmapped=1 afterwards.
